// File: rtl/tdm_mux_4x1.sv
// Four-lane valid/ready TDM merger with one registered output beat tagged by source lane; round-robin when TDM_MUX_ROUND_ROBIN_EN is defined, else fixed priority.
// Latency: one cycle from accept to f/sel. Backpressure: a stalled output beat holds f/sel/out_valid and closes every in_ready.
module tdm_mux_4x1 #(
  parameter int WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           in_valid,
  input  logic [4*WIDTH-1:0]   in_data,
  output logic [3:0]           in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     f,
  output logic [1:0]           sel
);

  logic       free;
  logic       grant_vld;
  logic [1:0] grant;
  logic [1:0] ptr;

  // Draining and refilling in the same cycle keeps the stream bubble-free.
  assign free = !out_valid || out_ready;

  always_comb begin
    grant_vld = 1'b0;
    grant     = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!grant_vld && in_valid[ptr + 2'(i)]) begin
        grant_vld = 1'b1;
        grant     = ptr + 2'(i);
      end
    end
  end

  always_comb begin
    in_ready = 4'b0000;
    if (rst_n && free && grant_vld) begin
      in_ready[grant] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      f         <= '0;
      sel       <= 2'd0;
    end else if (free) begin
      out_valid <= grant_vld;
      if (grant_vld) begin
        f   <= in_data[grant*WIDTH +: WIDTH];
        sel <= grant;
      end
    end
  end

`ifdef TDM_MUX_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 2'd0;
    end else if (free && grant_vld) begin
      ptr <= grant + 2'd1;
    end
  end
`else
  assign ptr = 2'd0;
`endif

endmodule

// File: tb/tb_tdm_mux_4x1.sv
// Bench for tdm_mux_4x1: directed scenarios then random traffic, all against a lane-search reference model.
module tb_tdm_mux_4x1;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [3:0]     in_valid;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_ready;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   f;
  logic [1:0]     sel;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit           m_valid;
  bit [W-1:0]   m_f;
  int           m_sel;
  int           m_ptr;

`ifdef TDM_MUX_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  tdm_mux_4x1 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .f(f), .sel(sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic bit [W-1:0] lane_data(input logic [4*W-1:0] d, input int lane);
    logic [4*W-1:0] t;
    t = d >> (lane * W);
    return t[W-1:0];
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_f = '0; m_sel = 0; m_ptr = 0;
  endtask

  // One cycle: drive, check in_ready, clock, advance model, check registered outputs.
  task automatic step(input logic [3:0] v, input logic [4*W-1:0] d, input logic r);
    int  g;
    bit  fr;
    logic [3:0] exp_rdy;
    in_valid = v; in_data = d; out_ready = r;
    #1;
    fr = !m_valid || r;
    g  = pick(v, m_ptr);
    exp_rdy = (fr && g >= 0) ? (4'b0001 << g) : 4'b0000;
    chk("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
    @(posedge clk);
    if (fr) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_f     = lane_data(d, g);
        m_sel   = g;
        if (RR) m_ptr = (g + 1) % 4;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("f", {24'd0, f}, {24'd0, m_f});
    chk("sel", {30'd0, sel}, m_sel);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 4'hf; in_data = '1; out_ready = 1'b1;
    model_reset();
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_f", {24'd0, f}, 0);
    chk("rst_sel", {30'd0, sel}, 0);
    chk("rst_in_ready", {28'd0, in_ready}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // All lanes valid: rotation from reset, or lane 0 forever under fixed priority
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, {8'h44, 8'h33, 8'h22, 8'h11}, 1'b1);
      chk("seq_sel", {30'd0, sel}, RR ? (i % 4) : 0);
      chk("seq_valid", {31'd0, out_valid}, 1);
    end

    // Mid-stream async reset discards the held beat without a clock edge
    in_valid = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 0);
    chk("mid_rst_f", {24'd0, f}, 0);
    chk("mid_rst_sel", {30'd0, sel}, 0);
    chk("mid_rst_in_ready", {28'd0, in_ready}, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single lane 2
    step(4'b0100, {8'h00, 8'h01, 8'h00, 8'h00}, 1'b1);
    chk("lane2_f", {24'd0, f}, 1);
    chk("lane2_sel", {30'd0, sel}, 2);

    // Backpressure on a lane-1 beat, then refill from lane 3 without a gap
    step(4'b0010, {8'h0d, 8'h0c, 8'hb1, 8'h0a}, 1'b1);
    chk("bp_load_sel", {30'd0, sel}, 1);
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, {8'hee, 8'hdd, 8'hcc, 8'hbb}, 1'b0);
      chk("bp_hold_f", {24'd0, f}, 32'hb1);
      chk("bp_hold_sel", {30'd0, sel}, 1);
      chk("bp_hold_valid", {31'd0, out_valid}, 1);
    end
    step(4'b1000, {8'h3f, 8'h00, 8'h00, 8'h00}, 1'b1);
    chk("bp_next_sel", {30'd0, sel}, 3);
    chk("bp_next_f", {24'd0, f}, 32'h3f);

    // Idle gap after lane 3, then lanes 0 and 3 compete
    step(4'b0000, '0, 1'b1);
    chk("gap_valid", {31'd0, out_valid}, 0);
    step(4'b0000, '0, 1'b1);
    chk("gap_valid2", {31'd0, out_valid}, 0);
    step(4'b1001, {8'h93, 8'h00, 8'h00, 8'h90}, 1'b1);
    chk("wrap_first_sel", {30'd0, sel}, 0);
    step(4'b1001, {8'h93, 8'h00, 8'h00, 8'h90}, 1'b1);
    chk("wrap_second_sel", {30'd0, sel}, RR ? 3 : 0);

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom), $urandom, ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
